fir_ap_ctrl: RTL and testbench
==============================

Name: fir_ap_ctrl

Overview:
Control/sequencer for the FIR engine. It is an AXI-Lite slave holding ap_ctrl (start/done/idle) and data_length, and it is the sole owner of the tap BRAM port for host tap programming and readback. It issues a one-cycle start to the FIR datapath and watches the output stream to decide completion. Tap access is blocked while the engine runs.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and BRAM address width
pDATA_WIDTH, 32, AXI-Lite and BRAM data width
Tape_Num, 11, number of taps; tap window is 0x20 .. 0x20+4*(Tape_Num-1)

Ports:
axis_clk  in  1  single clock
axis_rst  in  1  async, active-high reset
awvalid/awready  in/out  1  write address handshake
awaddr  in  pADDR_WIDTH  write address
wvalid/wready  in/out  1  write data handshake
wdata  in  pDATA_WIDTH  write data
bvalid/bready  out/in  1  write response
arvalid/arready  in/out  1  read address handshake
araddr  in  pADDR_WIDTH  read address
rvalid/rready  out/in  1  read data handshake
rdata  out  pDATA_WIDTH  read data
tap_WE  out  4  tap BRAM byte write enable
tap_EN  out  1  tap BRAM enable
tap_A  out  pADDR_WIDTH  tap BRAM byte address (offset minus 0x20)
tap_Di  out  pDATA_WIDTH  tap BRAM write data
tap_Do  in  pDATA_WIDTH  tap BRAM read data, 1-cycle latency
eng_start  out  1  one-cycle start pulse to FIR datapath
eng_len  out  pDATA_WIDTH  registered data_length for the datapath
sm_tvalid/sm_tready/sm_tlast  in  1 each  monitored FIR output stream
irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset (async): all outputs 0 except status ap_idle=1. FSM=IDLE. data_length=0. No pending B or R response.
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start, W1 accepted only in IDLE; reads 1 only in the START state. bit1 ap_done, RO, sticky, cleared by a read of 0x00. bit2 ap_idle, RO.
  - 0x10 data_length: RW; writes are ignored unless in IDLE.
  - Tap window: RW.
  - Any other address: reads 0, writes dropped but still get a response.
- Write channel:
  - Needs awvalid & wvalid & !bvalid.
  - awready and wready pulse together for 1 cycle (registered); the side effect occurs in that same cycle.
  - bvalid rises the next cycle and holds until bready.
- Read channel:
  - Needs arvalid & !rvalid & no read in flight; arready pulses for 1 cycle.
  - rvalid asserts exactly 2 cycles after the arready cycle for every address, and holds until rready.
  - rdata is stable while rvalid is high.
- Tap port:
  - Tap write: tap_EN=1, tap_WE=4'hF in the wready cycle.
  - Tap read: tap_EN=1, tap_WE=0 in the arready cycle; tap_Do is captured the next cycle.
  - If a tap write and a tap read are both eligible in one cycle, the write wins and arready is held low that cycle.
  - While FSM != IDLE: tap writes are dropped but acknowledged, tap reads return 32'hFFFF_FFFF, and tap_EN stays 0.
- FSM:
  - IDLE: W1 to ap_start -> START. ap_done is cleared on start.
  - START (1 cycle): if data_length==0 -> IDLE and set ap_done, no eng_start. Otherwise eng_start=1, ap_idle=0, -> RUN.
  - RUN: a 32-bit beat counter increments on each sm_tvalid & sm_tready. On the handshake where count+1 == data_length, or sm_tlast is high -> IDLE; ap_done=1 and ap_idle=1 on the next cycle.
  - A W1 to ap_start outside IDLE is ignored.
  - A read of 0x00 in the same cycle ap_done sets: set wins; the read returns the old value.
- eng_len = data_length, stable from START through RUN.
- An async reset mid-RUN aborts: FSM=IDLE, ap_idle=1, ap_done=0, the beat counter cleared, and pending responses dropped.

Optional Feature:
FIR_AP_CTRL_IRQ_EN
- Defined: register 0x04 bit0 is ie (RW, reset 0). irq = ap_done & ie, a level signal that drops when a read of 0x00 clears ap_done.
- Undefined: irq is tied 0, 0x04 reads 0, and writes to 0x04 are dropped.

Decomposition:
- Package fir_pkg holds:
  - address offsets ADDR_AP_CTRL, ADDR_LEN, ADDR_IE, ADDR_TAP_BASE;
  - status bit indices;
  - FSM state encoding IDLE/START/RUN;
  - the TAP_BUSY_RDATA constant (32'hFFFF_FFFF).
- One sub-module: fir_axil_slave, covering AW/W/B and AR/R handshake timing and the 2-cycle read pipeline. It exposes wr_en/wr_addr/wr_data, rd_en/rd_addr, and takes rd_data back.
- The FSM, register decode and tap muxing stay in fir_ap_ctrl.

Test Plan:
- Reset, then read 0x00 -> rdata=0x4. Read 0x10 -> 0.
- Write taps 0x20..0x48 with values 1..11, then read them back -> 1..11, each rvalid 2 cycles after arready. tap_A=0x00..0x28.
- Write 0x10=600, write 0x00=1 -> eng_start is a 1-cycle pulse and 0x00 reads 0x0 during RUN. After 600 sm handshakes, 0x00 reads 0x6; a second read returns 0x4.
- In RUN, write 0x24=0x55 and read 0x24 -> read returns 0xFFFF_FFFF and the tap keeps 2 (read after done -> 2). A write to 0x10 is ignored.
- Set length 0 and start -> no eng_start; ap_done=1 within 2 cycles. Also: assert reset mid-RUN after 100 beats -> ap_idle=1, ap_done=0, and a restart counts from 0.
- With FIR_AP_CTRL_IRQ_EN: set 0x04=1 and run length 5 -> irq rises with ap_done and falls after the 0x00 read. Without the macro, irq stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR control block: register offsets, status bits,
// sequencer states and the tap-window decode helper.
package fir_pkg;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_IE       = 'h04;
  localparam int ADDR_LEN      = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  localparam logic [31:0] TAP_BUSY_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } fir_state_e;

  function automatic logic is_tap(input logic [31:0] addr, input int tap_num);
    return (addr >= 32'(ADDR_TAP_BASE)) && (addr <= 32'(ADDR_TAP_BASE + 4 * (tap_num - 1)));
  endfunction

endpackage

// File: rtl/fir_ap_ctrl_if.sv
// AXI-Lite register bus between the host and the FIR control block.
interface fir_ap_ctrl_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   bvalid, bready;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_axil_slave.sv
// AXI-Lite handshake engine: single-beat writes, and reads with a fixed
// two-cycle pipeline (accept -> register/tap fetch -> rvalid).
module fir_axil_slave
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  fir_ap_ctrl_if.slave           axil,
  output logic                   wr_en,
  output logic [pADDR_WIDTH-1:0] wr_addr,
  output logic [pDATA_WIDTH-1:0] wr_data,
  output logic                   rd_en,
  output logic [pADDR_WIDTH-1:0] rd_addr,
  input  logic [pDATA_WIDTH-1:0] rd_data
);

  logic aw_go, ar_go, tap_clash, rd_p1;

  assign aw_go = axil.awvalid & axil.wvalid & ~axil.bvalid & ~axil.awready;
  // Tap write and tap read would share the BRAM port in the same cycle: write goes first.
  assign tap_clash = aw_go & is_tap(32'(axil.awaddr), Tape_Num)
                           & is_tap(32'(axil.araddr), Tape_Num);
  assign ar_go = axil.arvalid & ~axil.arready & ~rd_p1 & ~axil.rvalid & ~tap_clash;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      axil.awready <= 1'b0;
      axil.wready  <= 1'b0;
      axil.bvalid  <= 1'b0;
      axil.arready <= 1'b0;
      axil.rvalid  <= 1'b0;
      axil.rdata   <= '0;
      rd_p1        <= 1'b0;
    end else begin
      axil.awready <= aw_go;
      axil.wready  <= aw_go;
      if (axil.awready)     axil.bvalid <= 1'b1;
      else if (axil.bready) axil.bvalid <= 1'b0;
      axil.arready <= ar_go;
      rd_p1        <= axil.arready;
      if (rd_p1) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= rd_data;
      end else if (axil.rready) begin
        axil.rvalid <= 1'b0;
      end
    end
  end

  assign wr_en   = axil.wready;
  assign wr_addr = axil.awaddr;
  assign wr_data = axil.wdata;
  assign rd_en   = axil.arready;
  assign rd_addr = axil.araddr;

endmodule

// File: rtl/fir_ap_ctrl.sv
// FIR sequencer: ap_ctrl/data_length registers, tap BRAM owner and run tracking.
// Optional interrupt enable register at 0x04 built when FIR_AP_CTRL_IRQ_EN is defined.
module fir_ap_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  fir_ap_ctrl_if.slave           axil,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   eng_start,
  output logic [pDATA_WIDTH-1:0] eng_len,
  input  logic                   sm_tvalid,
  input  logic                   sm_tready,
  input  logic                   sm_tlast,
  output logic                   irq
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP  = pADDR_WIDTH'(ADDR_TAP_BASE);

  logic                   wr_en, rd_en;
  logic [pADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [pDATA_WIDTH-1:0] wr_data, rd_data, rd_val, rd_val_q;
  logic [pDATA_WIDTH-1:0] data_length, beat_cnt;
  logic                   ap_done, ap_idle, rd_tap_q;
  logic                   st_idle, wr_is_tap, rd_is_tap, start_wr, rd_ctrl, sm_hs;
  logic                   done_set;
  fir_state_e             state_q, state_d;

  fir_axil_slave #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .Tape_Num    (Tape_Num)
  ) u_slv (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .axil     (axil),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  assign st_idle   = (state_q == IDLE);
  assign wr_is_tap = is_tap(32'(wr_addr), Tape_Num);
  assign rd_is_tap = is_tap(32'(rd_addr), Tape_Num);
  assign start_wr  = wr_en && (wr_addr == A_CTRL) && wr_data[AP_START_BIT] && st_idle;
  assign rd_ctrl   = rd_en && (rd_addr == A_CTRL);
  assign sm_hs     = sm_tvalid & sm_tready;
  assign eng_len   = data_length;

  // Tap port is only driven while idle; a running engine owns the coefficients.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (wr_en && wr_is_tap && st_idle) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = wr_addr - A_TAP;
      tap_Di = wr_data;
    end else if (rd_en && rd_is_tap && st_idle) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr - A_TAP;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    done_set  = 1'b0;
    unique case (state_q)
      IDLE:  if (start_wr) state_d = START;
      START: begin
        if (data_length == '0) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          eng_start = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (sm_hs && ((beat_cnt + pDATA_WIDTH'(1) == data_length) || sm_tlast)) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Done set beats a clearing read of 0x00 landing in the same cycle.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      data_length <= '0;
      beat_cnt    <= '0;
    end else begin
      if (done_set) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else begin
        if (start_wr || rd_ctrl) ap_done <= 1'b0;
        if (eng_start)           ap_idle <= 1'b0;
      end
      if (wr_en && (wr_addr == A_LEN) && st_idle) data_length <= wr_data;
      if (state_q != RUN)  beat_cnt <= '0;
      else if (sm_hs)      beat_cnt <= (state_d == IDLE) ? '0 : beat_cnt + pDATA_WIDTH'(1);
    end
  end

`ifdef FIR_AP_CTRL_IRQ_EN
  logic ie;
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)                                          ie <= 1'b0;
    else if (wr_en && (wr_addr == pADDR_WIDTH'(ADDR_IE)))  ie <= wr_data[0];
  end
  assign irq = ap_done & ie;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    if (rd_addr == A_CTRL) begin
      rd_val[AP_START_BIT] = (state_q == START);
      rd_val[AP_DONE_BIT]  = ap_done;
      rd_val[AP_IDLE_BIT]  = ap_idle;
    end else if (rd_addr == A_LEN) begin
      rd_val = data_length;
`ifdef FIR_AP_CTRL_IRQ_EN
    end else if (rd_addr == pADDR_WIDTH'(ADDR_IE)) begin
      rd_val[0] = ie;
`endif
    end else if (rd_is_tap && !st_idle) begin
      rd_val = pDATA_WIDTH'(TAP_BUSY_RDATA);
    end
  end

  // Register values are snapped at accept; tap data arrives from the BRAM one cycle later.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rd_tap_q <= 1'b0;
      rd_val_q <= '0;
    end else if (rd_en) begin
      rd_tap_q <= rd_is_tap && st_idle;
      rd_val_q <= rd_val;
    end
  end

  assign rd_data = rd_tap_q ? tap_Do : rd_val_q;

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Self-checking bench for fir_ap_ctrl: register table, tap programming, run
// sequencing with randomized stream stalls against a beat-count reference model.
module tb_fir_ap_ctrl;
  import fir_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef FIR_AP_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Di, tap_Do;
  logic          eng_start, irq;
  logic [DW-1:0] eng_len;
  logic          sm_tvalid = 1'b0, sm_tready = 1'b0, sm_tlast = 1'b0;

  fir_ap_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axil ();

  fir_ap_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .axil      (axil),
    .tap_WE    (tap_WE),
    .tap_EN    (tap_EN),
    .tap_A     (tap_A),
    .tap_Di    (tap_Di),
    .tap_Do    (tap_Do),
    .eng_start (eng_start),
    .eng_len   (eng_len),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tlast  (sm_tlast),
    .irq       (irq)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM: one-cycle read latency.
  logic [31:0] bram [0:15];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  // eng_start pulse counter and width monitor.
  int   es_cnt = 0, es_wide = 0;
  logic es_prev = 1'b0;
  always @(negedge axis_clk) begin
    if (eng_start) begin
      es_cnt++;
      if (es_prev) es_wide++;
    end
    es_prev = eng_start;
  end

  int          checks = 0, failures = 0;
  logic [31:0] exp_taps [0:10];
  bit          ie_model = 1'b0;
  int          run_beats = 0;
  logic        w_tap_en, r_tap_en;
  logic [3:0]  w_tap_we, r_tap_we;
  logic [11:0] w_tap_a, r_tap_a;
  logic [31:0] w_tap_di;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    axil.awaddr = a; axil.wdata = d; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!axil.awready && n < 20);
    if (!axil.awready) begin
      tmo("wr_accept");
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      return;
    end
    chk("w_pair", axil.wready, 1'b1);
    w_tap_en = tap_EN; w_tap_we = tap_WE; w_tap_a = tap_A; w_tap_di = tap_Di;
    @(negedge axis_clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    chk("bvalid", axil.bvalid, 1'b1);
    @(negedge axis_clk);
    if (a == 12'(ADDR_IE) && IRQ_ON) ie_model = d[0];
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    int n = 0, lat;
    d = '0;
    axil.araddr = a; axil.arvalid = 1'b1;
    do begin @(negedge axis_clk); n++; end while (!axil.arready && n < 20);
    if (!axil.arready) begin
      tmo("rd_accept");
      axil.arvalid = 1'b0;
      return;
    end
    r_tap_en = tap_EN; r_tap_we = tap_WE; r_tap_a = tap_A;
    @(negedge axis_clk);
    axil.arvalid = 1'b0;
    lat = 1;
    while (!axil.rvalid && lat < 10) begin @(negedge axis_clk); lat++; end
    if (!axil.rvalid) begin tmo("rd_valid"); return; end
    d = axil.rdata;
    chk("rd_lat", lat, 2);
    @(negedge axis_clk);
    chk("rd_hold", {axil.rvalid, axil.rdata}, {1'b1, d});
    axil.rready = 1'b1;
    @(negedge axis_clk);
    axil.rready = 1'b0;
  endtask

  // Issues n stream handshakes with random stalls; tlast on handshake number tl of the run.
  task automatic drive_beats(input int n, input int tl);
    int got = 0, guard = 0;
    while (got < n) begin
      if (guard++ > 4000) begin tmo("beats"); break; end
      sm_tvalid = ($urandom_range(0, 3) != 0);
      sm_tready = ($urandom_range(0, 3) != 0);
      sm_tlast  = (run_beats + 1 == tl);
      @(negedge axis_clk);
      if (sm_tvalid && sm_tready) begin got++; run_beats++; end
    end
    sm_tvalid = 1'b0; sm_tready = 1'b0; sm_tlast = 1'b0;
  endtask

  // Reference: the run completes on handshake min(len, tl) (tl=0 means no tlast).
  task automatic run_check(input int len, input int tl);
    logic [31:0] d;
    int endb, es0;
    endb = (tl > 0 && tl < len) ? tl : len;
    wr(12'(ADDR_LEN), 32'(len));
    es0 = es_cnt;
    wr(12'(ADDR_AP_CTRL), 32'h1);
    run_beats = 0;
    rd(12'(ADDR_AP_CTRL), d);  chk("run_busy", d, 32'h0);
    chk("run_start", es_cnt, es0 + 1);
    chk("eng_len", eng_len, 32'(len));
    if (endb > 1) begin
      drive_beats(endb - 1, tl);
      rd(12'(ADDR_AP_CTRL), d); chk("run_pre", d, 32'h0);
    end
    drive_beats(1, tl);
    repeat (2) @(negedge axis_clk);
    chk("irq_on", irq, ie_model);
    rd(12'(ADDR_AP_CTRL), d);  chk("run_done", d, 32'h6);
    chk("irq_off", irq, 1'b0);
    rd(12'(ADDR_AP_CTRL), d);  chk("run_clr", d, 32'h4);
  endtask

  initial begin
    vec_t        tbl [12];
    logic [31:0] d, rdat;
    int          es0, w_cyc, r_cyc, idx, len, tl;
    bit          w_hs, r_hs, rgot;

    axil.awvalid = 0; axil.awaddr = '0; axil.wvalid = 0; axil.wdata = '0; axil.bready = 1'b1;
    axil.arvalid = 0; axil.araddr = '0; axil.rready = 0;

    tbl[0]  = '{1'b0, 12'h000, 32'h0,        32'h4};
    tbl[1]  = '{1'b0, 12'h010, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 12'h004, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 12'h010, 32'd600,      32'h0};
    tbl[4]  = '{1'b0, 12'h010, 32'h0,        32'd600};
    tbl[5]  = '{1'b1, 12'h008, 32'hDEAD,     32'h0};
    tbl[6]  = '{1'b0, 12'h008, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 12'h04C, 32'h1234,     32'h0};
    tbl[8]  = '{1'b0, 12'h04C, 32'h0,        32'h0};
    tbl[9]  = '{1'b1, 12'h004, 32'h1,        32'h0};
    tbl[10] = '{1'b0, 12'h004, 32'h0,        IRQ_ON ? 32'h1 : 32'h0};
    tbl[11] = '{1'b1, 12'h004, 32'h0,        32'h0};

    repeat (2) @(negedge axis_clk);
    chk("rst_outs", {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid,
                     tap_EN, tap_WE, eng_start, irq}, 32'h0);
    axis_rst = 1'b0;
    @(negedge axis_clk);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
        chk("tbl_no_tap", w_tap_en, 1'b0);
      end else begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl%0d", i), d, tbl[i].exp);
      end
    end

    for (int i = 0; i < 11; i++) begin
      wr(12'(32'h20 + 4 * i), 32'(i + 1));
      exp_taps[i] = 32'(i + 1);
      chk("tw_port", {w_tap_en, w_tap_we, w_tap_a, w_tap_di},
          {1'b1, 4'hF, 12'(4 * i), 32'(i + 1)});
    end
    for (int i = 0; i < 11; i++) begin
      rd(12'(32'h20 + 4 * i), d);
      chk("tr_data", d, exp_taps[i]);
      chk("tr_port", {r_tap_en, r_tap_we, r_tap_a}, {1'b1, 4'h0, 12'(4 * i)});
    end

    // Simultaneous tap write and tap read of 0x28: write must go first.
    w_hs = 0; r_hs = 0; rgot = 0; w_cyc = -1; r_cyc = -1; rdat = '0;
    axil.rready = 1'b1;
    axil.awaddr = 12'h028; axil.wdata = 32'h77; axil.awvalid = 1; axil.wvalid = 1;
    axil.araddr = 12'h028; axil.arvalid = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge axis_clk);
      if (w_hs) begin axil.awvalid = 0; axil.wvalid = 0; w_hs = 0; end
      if (r_hs) begin axil.arvalid = 0; r_hs = 0; end
      if (axil.awready) begin w_hs = 1; w_cyc = k; end
      if (axil.arready) begin r_hs = 1; r_cyc = k; end
      if (axil.rvalid && !rgot) begin rgot = 1; rdat = axil.rdata; end
    end
    axil.rready = 1'b0;
    exp_taps[2] = 32'h77;
    chk("coll_order", (w_cyc >= 0) && (w_cyc < r_cyc), 1'b1);
    chk("coll_rd", rdat, 32'h77);

    run_check(600, 0);

    // Tap access and register writes while running.
    wr(12'(ADDR_LEN), 32'd20);
    es0 = es_cnt;
    wr(12'(ADDR_AP_CTRL), 32'h1);
    run_beats = 0;
    drive_beats(5, 0);
    wr(12'h024, 32'h55);       chk("busy_tw_en", w_tap_en, 1'b0);
    rd(12'h024, d);            chk("busy_tr", d, 32'hFFFF_FFFF);
    chk("busy_tr_en", r_tap_en, 1'b0);
    wr(12'(ADDR_LEN), 32'd7);
    wr(12'(ADDR_AP_CTRL), 32'h1);
    drive_beats(15, 0);
    rd(12'(ADDR_AP_CTRL), d);  chk("busy_done", d, 32'h6);
    rd(12'(ADDR_LEN), d);      chk("busy_len", d, 32'd20);
    rd(12'h024, d);            chk("busy_tap", d, exp_taps[1]);
    chk("busy_starts", es_cnt, es0 + 1);

    // Zero length: completes without a start pulse.
    wr(12'(ADDR_LEN), 32'd0);
    es0 = es_cnt;
    wr(12'(ADDR_AP_CTRL), 32'h1);
    rd(12'(ADDR_AP_CTRL), d);  chk("len0_done", d, 32'h6);
    chk("len0_nostart", es_cnt, es0);
    rd(12'(ADDR_AP_CTRL), d);  chk("len0_clr", d, 32'h4);

    wr(12'(ADDR_IE), 32'h1);
    run_check(5, 0);

    // Reset in the middle of a run.
    wr(12'(ADDR_LEN), 32'd300);
    wr(12'(ADDR_AP_CTRL), 32'h1);
    run_beats = 0;
    drive_beats(100, 0);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    chk("mrst_outs", {axil.bvalid, axil.rvalid, eng_start, irq, tap_EN}, 32'h0);
    axis_rst = 1'b0;
    ie_model = 1'b0;
    @(negedge axis_clk);
    rd(12'(ADDR_AP_CTRL), d);  chk("mrst_ctrl", d, 32'h4);
    rd(12'(ADDR_LEN), d);      chk("mrst_len", d, 32'h0);
    run_check(5, 0);

    // Randomized tap traffic against the tap model.
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 10);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wr(12'(32'h20 + 4 * idx), d);
        exp_taps[idx] = d;
        chk("rnd_tw_a", w_tap_a, 12'(4 * idx));
      end else begin
        rd(12'(32'h20 + 4 * idx), d);
        chk("rnd_tr", d, exp_taps[idx]);
      end
    end

    // Randomized runs with optional early tlast.
    for (int i = 0; i < 5; i++) begin
      len = $urandom_range(1, 40);
      tl  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len + 5) : 0;
      run_check(len, tl);
    end

    chk("es_width", es_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
